// File: rtl/ctrl_sequencer_pkg.sv
// rtl/ctrl_sequencer_pkg.sv - shared opcode, ALU code and time-step definitions
//
// Purpose: constants shared by the control sequencer and the datapath ALU.
//   OP_*  : 4-bit instruction opcodes (IR[15:12]); 8..15 are illegal.
//   ALU_* : 3-bit ALU operation codes driven on "controle".
//   state_t : the four time steps T0..T3 of the sequencer.
package ctrl_sequencer_pkg;

    localparam logic [3:0] OP_MV  = 4'd0;
    localparam logic [3:0] OP_MVI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SRL);
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        logic [2:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_SLT:  code = ALU_SLT;
            OP_SLL:  code = ALU_SLL;
            OP_SRL:  code = ALU_SRL;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_dec3to8.sv
// rtl/ctrl_sequencer_dec3to8.sv - 3-to-8 one-hot decoder with enable
//
// Purpose: turns a 3-bit register index into a one-hot register enable.
// Ports:
//   en     in  1  decoder enable; output is all-zero when low
//   sel    in  3  register index
//   onehot out 8  one-hot decode of sel, or zero
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = 8'b0;
        if (en) begin
            onehot = 8'b1 << sel;
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - multicycle control unit sequencing T0..T3 for the datapath ALU
//
// Purpose: latches an instruction from DIN on Run, decodes it and drives the
// datapath enables over time steps T0..T3. One instruction in flight.
// Ports:
//   Clock    in  1       system clock, rising edge
//   Resetn   in  1       asynchronous active-low reset
//   Run      in  1       start request, sampled only in T0
//   DIN      in  DATA_W  instruction word (T0) / mvi immediate (T1)
//   Rin      out NREG    one-hot register write enable (index X)
//   Rout     out NREG    one-hot register bus drive (index X or Y)
//   DINout   out 1       drive DIN onto the bus
//   Ain      out 1       load A from the bus
//   Gin      out 1       load G from the ALU result
//   Gout     out 1       drive G onto the bus
//   controle out 3       ALU operation code (non-zero only in T2)
//   Done     out 1       single-cycle pulse in the final step
//   Busy     out 1       high whenever the sequencer is not in T0
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8    // fixed at 8: X/Y fields are 3 bits wide
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [NREG-1:0]   Rin,
    output logic [NREG-1:0]   Rout,
    output logic              DINout,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic [2:0]        controle,
    output logic              Done,
    output logic              Busy
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] ir;

    logic [3:0] opcode;
    logic [2:0] ir_x;
    logic [2:0] ir_y;

    assign opcode = ir[15:12];
    assign ir_x   = ir[11:9];
    assign ir_y   = ir[8:6];

    // IR[5:0] carries no meaning for this instruction set.
    logic ir_low_unused;
    assign ir_low_unused = ^ir[5:0];

    logic       ir_load;
    logic       rin_en;
    logic       rout_en;
    logic [2:0] rout_sel;
    logic       dinout_c;
    logic       ain_c;
    logic       gin_c;
    logic       gout_c;
    logic [2:0] ctrl_c;
    logic       done_c;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (ir_load) begin
                ir <= DIN;
            end
        end
    end

    always_comb begin
        next_state = state;
        ir_load    = 1'b0;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        rout_sel   = ir_y;
        dinout_c   = 1'b0;
        ain_c      = 1'b0;
        gin_c      = 1'b0;
        gout_c     = 1'b0;
        ctrl_c     = ALU_ADD;
        done_c     = 1'b0;

        case (state)
            T0: begin
                if (Run) begin
                    ir_load    = 1'b1;
                    next_state = T1;
                end
            end
            T1: begin
                if (opcode == OP_MV) begin
                    rout_en    = 1'b1;
                    rout_sel   = ir_y;
                    rin_en     = 1'b1;
                    done_c     = 1'b1;
                    next_state = T0;
                end else if (opcode == OP_MVI) begin
                    dinout_c   = 1'b1;
                    rin_en     = 1'b1;
                    done_c     = 1'b1;
                    next_state = T0;
                end else if (is_alu_op(opcode)) begin
                    rout_en    = 1'b1;
                    rout_sel   = ir_x;
                    ain_c      = 1'b1;
                    next_state = T2;
                end else begin
                    // Illegal opcode retires as a no-op.
                    done_c     = 1'b1;
                    next_state = T0;
                end
            end
            T2: begin
                rout_en    = 1'b1;
                rout_sel   = ir_y;
                gin_c      = 1'b1;
                ctrl_c     = alu_code(opcode);
                next_state = T3;
            end
            T3: begin
                gout_c     = 1'b1;
                rin_en     = 1'b1;
                done_c     = 1'b1;
                next_state = T0;
            end
            default: begin
                next_state = T0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, even the purely
    // combinational ones, so nothing downstream sees a glitch during reset.
    dec3to8 u_rin_dec (
        .en     (Resetn & rin_en),
        .sel    (ir_x),
        .onehot (Rin)
    );

    dec3to8 u_rout_dec (
        .en     (Resetn & rout_en),
        .sel    (rout_sel),
        .onehot (Rout)
    );

    assign DINout   = Resetn & dinout_c;
    assign Ain      = Resetn & ain_c;
    assign Gin      = Resetn & gin_c;
    assign Gout     = Resetn & gout_c;
    assign controle = Resetn ? ctrl_c : 3'b000;
    assign Done     = Resetn & done_c;
    assign Busy     = Resetn & (state != T0);

endmodule
